// File: rtl/cube_pkg.sv
// Shared definitions for the cube unit and its cube-root companion.
package cube_pkg;

  // FSM encoding for the sequential cube unit.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SQ_LOAD = 3'd1,
    SQ_RUN  = 3'd2,
    CU_LOAD = 3'd3,
    CU_RUN  = 3'd4,
    WB      = 3'd5
  } cube_state_e;

  // Step counter width for a W-bit operand.
  // W=1 still gets a 1-bit counter so the compare stays legal.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/cube_mul_step.sv
// Shift-add multiplier datapath: one partial product per step.
// The cube FSM sequences it; this block has no control of its own.
module cube_mul_step
  import cube_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [3*W-1:0] a_bi,
  input  logic [W-1:0]   b_bi,
  output logic [3*W-1:0] acc_bo
);

  logic [3*W-1:0] a_q, acc_q;
  logic [W-1:0]   b_q;

  // Load takes priority over step.
  // A step adds the shifted multiplicand when the current multiplier LSB is set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (load_i) begin
      a_q   <= a_bi;
      b_q   <= b_bi;
      acc_q <= '0;
    end else if (step_i) begin
      if (b_q[0]) acc_q <= acc_q + a_q;
      a_q <= a_q << 1;
      b_q <= b_q >> 1;
    end
  end

  assign acc_bo = acc_q;

endmodule

// File: rtl/cube.sv
// Sequential unsigned cube: y = x^3.
// The shared multiplier runs twice, first for x*x and then for (x*x)*x.
// Every operation takes the same fixed number of cycles.
module cube
  import cube_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [W-1:0]   x_bi,
  input  logic           start_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [3*W-1:0] y_bo
);

  localparam int CNT_W = cnt_w(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  cube_state_e    state_q, state_d;
  logic [W-1:0]   x_q, x_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3*W-1:0] y_q, y_d;
  logic           done_q, done_d;

  logic           mul_load, mul_step;
  logic [3*W-1:0] mul_a, acc;

  cube_mul_step #(.W(W)) u_mul (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (mul_load),
    .step_i (mul_step),
    .a_bi   (mul_a),
    .b_bi   (x_q),
    .acc_bo (acc)
  );

  // State, operand, counter and result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      x_q     <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic and multiplier control.
  // The square pass loads zero-extended x; the cube pass reloads the x^2 accumulator.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    done_d   = 1'b0;
    mul_load = 1'b0;
    mul_step = 1'b0;
    mul_a    = {{(2*W){1'b0}}, x_q};
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          x_d     = x_bi;
          state_d = SQ_LOAD;
        end
      end
      SQ_LOAD: begin
        mul_load = 1'b1;
        cnt_d    = '0;
        state_d  = SQ_RUN;
      end
      SQ_RUN: begin
        mul_step = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = CU_LOAD;
      end
      CU_LOAD: begin
        mul_load = 1'b1;
        mul_a    = acc;
        cnt_d    = '0;
        state_d  = CU_RUN;
      end
      CU_RUN: begin
        mul_step = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = WB;
      end
      WB: begin
        y_d     = acc;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign y_bo   = y_q;

endmodule
